dmem_arbiter: RTL

Two-port arbiter sharing the single-ported data memory (DTMemory plus memory-mapped Device window at 0x4xxxxxxx) between the CPU MEM stage (port C) and a DMA/loader engine (port D). CPU normally has priority. A starvation counter forces a bounded DMA burst so the loader always makes progress. The block sits between the MEM pipeline stage and the data memory, and drives a stall to the hazard unit.

---
 rtl/dmem_pkg.sv | 15 +
 rtl/dmem_arbiter_if.sv | 60 ++++++
 rtl/arb_starve_ctr.sv | 61 ++++++
 rtl/dmem_arbiter.sv | 119 +++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter: FSM state encoding and
// the base address of the memory-mapped Device window.
package dmem_pkg;

    typedef logic [1:0] arb_state_t;

    // Arbiter ownership states
    localparam arb_state_t ST_IDLE  = 2'd0;
    localparam arb_state_t ST_OWN_C = 2'd1;
    localparam arb_state_t ST_OWN_D = 2'd2;

    // Device window base (0x4xxxxxxx); decoding is done inside the memory
    localparam logic [31:0] DEVICE_BASE = 32'h4000_0000;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two requesters (CPU MEM stage, DMA/loader), the
// arbiter and the single-ported data memory.
//
// Handshake: a requester raises *_req with *_we/*_addr/*_wdata and holds
// them stable until it sees *_ack high in a cycle; that cycle is the access
// (read data valid in *_rdata during it, a write commits at the closing
// clock edge). Dropping *_req before *_ack is legal and cancels the access.
interface dmem_arbiter_if;
    import dmem_pkg::*;

    // Port C (CPU MEM stage)
    logic        cpu_req;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_ack;
    logic        cpu_stall;

    // Port D (DMA / loader)
    logic        dma_req;
    logic        dma_we;
    logic [31:0] dma_addr;
    logic [31:0] dma_wdata;
    logic [31:0] dma_rdata;
    logic        dma_ack;

    // Data memory side
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    // Debug view of the arbiter FSM
    arb_state_t  arb_state;

    // Arbiter side
    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_ack, cpu_stall,
        input  dma_req, dma_we, dma_addr, dma_wdata,
        output dma_rdata, dma_ack,
        output mem_read, mem_write, mem_addr, mem_wdata,
        input  mem_rdata,
        output arb_state
    );

    // Requester / memory side
    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_ack, cpu_stall,
        output dma_req, dma_we, dma_addr, dma_wdata,
        input  dma_rdata, dma_ack,
        input  mem_read, mem_write, mem_addr, mem_wdata,
        output mem_rdata,
        input  arb_state
    );

endinterface

// File: rtl/arb_starve_ctr.sv
// DMA starvation and burst counters. wait_cnt counts cycles the DMA spends
// requesting without an ack; when it reaches STARVE_LIMIT the arbiter is
// told to force a DMA burst. burst_cnt tracks the accesses left in that burst.
module arb_starve_ctr #(
    parameter int STARVE_LIMIT = 8,
    parameter int BURST_LEN    = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic dma_req_i,
    input  logic dma_ack_i,
    input  logic burst_load_i,
    input  logic burst_clr_i,
    output logic force_o,
    output logic burst_done_o
);

    localparam logic [7:0] LIMIT_W    = 8'(STARVE_LIMIT);
    localparam logic [3:0] BURST_INIT = 4'(BURST_LEN - 1);

    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic [3:0] burst_cnt_q, burst_cnt_d;

    // Waiting-cycle counter: clear on a DMA ack, saturate at the limit
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (dma_ack_i) begin
            wait_cnt_d = '0;
        end else if (dma_req_i && (wait_cnt_q != LIMIT_W)) begin
            wait_cnt_d = wait_cnt_q + 8'd1;
        end
    end

    // Burst counter: loaded on forced entry, zeroed on unforced entry,
    // decremented per DMA ack down to 0
    always_comb begin
        burst_cnt_d = burst_cnt_q;
        if (burst_load_i) begin
            burst_cnt_d = BURST_INIT;
        end else if (burst_clr_i) begin
            burst_cnt_d = '0;
        end else if (dma_ack_i && (burst_cnt_q != 4'd0)) begin
            burst_cnt_d = burst_cnt_q - 4'd1;
        end
    end

    // Counter registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt_q  <= '0;
            burst_cnt_q <= '0;
        end else begin
            wait_cnt_q  <= wait_cnt_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

    assign force_o      = (wait_cnt_q == LIMIT_W) && dma_req_i;
    assign burst_done_o = (burst_cnt_q == 4'd0);

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter for the single-ported data memory: CPU MEM stage (port C)
// normally wins, a starvation counter forces bounded DMA bursts (port D).
// Optional build macro DMEM_ARB_PERF_EN adds ack/conflict performance counters.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int STARVE_LIMIT = 8,
    parameter int BURST_LEN    = 4
) (
    input  logic        clk,
    input  logic        rst,
    dmem_arbiter_if.slave bus
`ifdef DMEM_ARB_PERF_EN
    ,
    output logic [31:0] perf_cpu_cnt,
    output logic [31:0] perf_dma_cnt,
    output logic [31:0] perf_conflict_cnt
`endif
);

    arb_state_t state_q, state_d;
    logic       cpu_ack_w, dma_ack_w;
    logic       force_w, burst_done_w;
    logic       burst_load_w, burst_clr_w;

    arb_starve_ctr #(
        .STARVE_LIMIT (STARVE_LIMIT),
        .BURST_LEN    (BURST_LEN)
    ) u_starve (
        .clk          (clk),
        .rst          (rst),
        .dma_req_i    (bus.dma_req),
        .dma_ack_i    (dma_ack_w),
        .burst_load_i (burst_load_w),
        .burst_clr_i  (burst_clr_w),
        .force_o      (force_w),
        .burst_done_o (burst_done_w)
    );

    // One access per cycle: the owner is acked while it keeps requesting
    assign cpu_ack_w = (state_q == ST_OWN_C) && bus.cpu_req;
    assign dma_ack_w = (state_q == ST_OWN_D) && bus.dma_req;

    // Next owner, in priority order: forced DMA burst, burst continuation,
    // CPU, unforced DMA, idle
    always_comb begin
        state_d      = ST_IDLE;
        burst_load_w = 1'b0;
        burst_clr_w  = 1'b0;
        if (force_w && (state_q != ST_OWN_D)) begin
            state_d      = ST_OWN_D;
            burst_load_w = 1'b1;
        end else if ((state_q == ST_OWN_D) && bus.dma_req &&
                     (!burst_done_w || !bus.cpu_req)) begin
            state_d = ST_OWN_D;
        end else if (bus.cpu_req) begin
            state_d = ST_OWN_C;
        end else if (bus.dma_req) begin
            state_d     = ST_OWN_D;
            burst_clr_w = 1'b1;
        end
    end

    // Ownership register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Memory drive: only an acked access reaches the memory, otherwise zeros
    always_comb begin
        bus.mem_addr  = 32'd0;
        bus.mem_wdata = 32'd0;
        if (cpu_ack_w) begin
            bus.mem_addr  = bus.cpu_addr;
            bus.mem_wdata = bus.cpu_wdata;
        end else if (dma_ack_w) begin
            bus.mem_addr  = bus.dma_addr;
            bus.mem_wdata = bus.dma_wdata;
        end
    end

    assign bus.mem_read  = (cpu_ack_w && !bus.cpu_we) || (dma_ack_w && !bus.dma_we);
    assign bus.mem_write = (cpu_ack_w && bus.cpu_we)  || (dma_ack_w && bus.dma_we);

    // Read data is steered to the current owner only
    assign bus.cpu_rdata = (state_q == ST_OWN_C) ? bus.mem_rdata : 32'd0;
    assign bus.dma_rdata = (state_q == ST_OWN_D) ? bus.mem_rdata : 32'd0;

    assign bus.cpu_ack   = cpu_ack_w;
    assign bus.dma_ack   = dma_ack_w;
    assign bus.cpu_stall = bus.cpu_req && !cpu_ack_w;
    assign bus.arb_state = state_q;

`ifdef DMEM_ARB_PERF_EN
    logic [31:0] perf_cpu_q, perf_dma_q, perf_conf_q;

    // Free-running wrap-around counters of acks and contended cycles
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_cpu_q  <= '0;
            perf_dma_q  <= '0;
            perf_conf_q <= '0;
        end else begin
            if (cpu_ack_w) perf_cpu_q <= perf_cpu_q + 32'd1;
            if (dma_ack_w) perf_dma_q <= perf_dma_q + 32'd1;
            if (bus.cpu_req && bus.dma_req) perf_conf_q <= perf_conf_q + 32'd1;
        end
    end

    assign perf_cpu_cnt      = perf_cpu_q;
    assign perf_dma_cnt      = perf_dma_q;
    assign perf_conflict_cnt = perf_conf_q;
`endif

endmodule
